// File: rtl/ram_arb_pkg.sv
// Shared definitions for the work-RAM port arbiter: FSM states and default sizes.
package ram_arb_pkg;

   localparam int unsigned RAM_AW      = 15;
   localparam int unsigned RAM_DW      = 32;
   localparam int unsigned RAM_TIMEOUT = 255;
   localparam int unsigned CNT_W       = 8;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDone
   } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig_i searching upward from last_i+1.
module rr_pick #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0] elig_i,
   input  logic [1:0]      last_i,
   output logic [1:0]      idx_o,
   output logic            valid_o
);

   int unsigned     j;
   logic [NREQ-1:0] rot;

   // Walk the NREQ candidates in priority order; the first eligible one wins.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      j       = 0;
      rot     = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         j   = (32'(last_i) + i) % NREQ;
         rot = elig_i >> j;
         if (!valid_o && rot[0]) begin
            valid_o = 1'b1;
            idx_o   = j[1:0];
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter serialising whole transactions from NREQ masters onto one RAM port.
import ram_arb_pkg::*;

module ram_port_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned AW      = RAM_AW,
   parameter int unsigned DW      = RAM_DW,
   parameter int unsigned TIMEOUT = RAM_TIMEOUT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] din,
   output logic [NREQ-1:0]  done,
   output logic             err,
   output logic [DW-1:0]    dout,
   output logic             busy,
   output logic [1:0]       gnt_id,
   output logic [AW-1:0]    ram_addr,
   output logic [DW-1:0]    ram_din,
   output logic             ram_we,
   output logic             ram_start,
   input  logic [DW-1:0]    ram_dout,
   input  logic             ram_readrdy,
   input  logic             ram_saverdy
);

   arb_state_e       state_q, state_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [1:0]       last_q, last_d;
   logic             we_q, we_d;
   logic [AW-1:0]    ram_addr_q, ram_addr_d;
   logic [DW-1:0]    ram_din_q, ram_din_d;
   logic             ram_we_q, ram_we_d;
   logic             ram_start_q, ram_start_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic             err_q, err_d;
   logic [DW-1:0]    dout_q, dout_d;
   logic [NREQ-1:0]  mask_q, mask_d;

   logic [NREQ-1:0]  elig;
   logic [1:0]       pick_idx;
   logic             pick_valid;
   logic             sel_we;
   logic [AW-1:0]    sel_addr;
   logic [DW-1:0]    sel_din;
   logic [NREQ-1:0]  gnt_onehot;
   logic             ready_match;

   // The served requester is hidden for one IDLE cycle so a late req drop is not re-granted.
   assign elig = req & ~mask_q;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .elig_i  (elig),
      .last_i  (last_q),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // Mux out the picked requester's command fields.
   always_comb begin
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_din  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick_idx == 2'(i)) begin
            sel_we   = we[i];
            sel_addr = addr[i*AW +: AW];
            sel_din  = din[i*DW +: DW];
         end
      end
   end

   assign gnt_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
   // Only the ready matching the transaction direction counts.
   assign ready_match = we_q ? ram_saverdy : ram_readrdy;

   // Next-state logic for the transaction FSM, latches and timeout counter.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      we_d        = we_q;
      ram_addr_d  = ram_addr_q;
      ram_din_d   = ram_din_q;
      ram_we_d    = 1'b0;
      ram_start_d = 1'b0;
      cnt_d       = cnt_q;
      done_d      = '0;
      err_d       = 1'b0;
      dout_d      = '0;
      mask_d      = mask_q;
      unique case (state_q)
         StIdle: begin
            mask_d = '0;
            if (pick_valid) begin
               gnt_d       = pick_idx;
               we_d        = sel_we;
               ram_addr_d  = sel_addr;
               ram_din_d   = sel_din;
               // Strobes are registered so they are high exactly during ISSUE.
               ram_we_d    = sel_we;
               ram_start_d = ~sel_we;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (ready_match) begin
               done_d  = gnt_onehot;
               dout_d  = we_q ? '0 : ram_dout;
               state_d = StDone;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               done_d  = gnt_onehot;
               err_d   = 1'b1;
               state_d = StDone;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            last_d  = gnt_q;
            mask_d  = gnt_onehot;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         gnt_q       <= '0;
         last_q      <= 2'(NREQ-1);
         we_q        <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
         ram_we_q    <= 1'b0;
         ram_start_q <= 1'b0;
         cnt_q       <= '0;
         done_q      <= '0;
         err_q       <= 1'b0;
         dout_q      <= '0;
         mask_q      <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         last_q      <= last_d;
         we_q        <= we_d;
         ram_addr_q  <= ram_addr_d;
         ram_din_q   <= ram_din_d;
         ram_we_q    <= ram_we_d;
         ram_start_q <= ram_start_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
         dout_q      <= dout_d;
         mask_q      <= mask_d;
      end
   end

   assign done      = done_q;
   assign err       = err_q;
   assign dout      = dout_q;
   assign busy      = (state_q != StIdle);
   assign gnt_id    = gnt_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;
   assign ram_we    = ram_we_q;
   assign ram_start = ram_start_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter; a second instance with a short timeout covers abort.
module tb_ram_port_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [3:0]   we;
   logic [59:0]  addr;
   logic [127:0] din;
   logic [31:0]  ram_dout;
   logic         ram_readrdy;
   logic         ram_saverdy;

   logic [3:0]   done,   t_done;
   logic         err,    t_err;
   logic [31:0]  dout,   t_dout;
   logic         busy,   t_busy;
   logic [1:0]   gnt_id, t_gnt_id;
   logic [14:0]  ram_addr, t_ram_addr;
   logic [31:0]  ram_din,  t_ram_din;
   logic         ram_we,   t_ram_we;
   logic         ram_start, t_ram_start;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(
      .NREQ (4), .AW (15), .DW (32), .TIMEOUT (255)
   ) dut (
      .clk_i (clk), .rst_i (rst), .req (req), .we (we), .addr (addr), .din (din),
      .done (done), .err (err), .dout (dout), .busy (busy), .gnt_id (gnt_id),
      .ram_addr (ram_addr), .ram_din (ram_din), .ram_we (ram_we), .ram_start (ram_start),
      .ram_dout (ram_dout), .ram_readrdy (ram_readrdy), .ram_saverdy (ram_saverdy)
   );

   ram_port_arbiter #(
      .NREQ (4), .AW (15), .DW (32), .TIMEOUT (4)
   ) dut_to (
      .clk_i (clk), .rst_i (rst), .req (req), .we (we), .addr (addr), .din (din),
      .done (t_done), .err (t_err), .dout (t_dout), .busy (t_busy), .gnt_id (t_gnt_id),
      .ram_addr (t_ram_addr), .ram_din (t_ram_din), .ram_we (t_ram_we),
      .ram_start (t_ram_start),
      .ram_dout (ram_dout), .ram_readrdy (ram_readrdy), .ram_saverdy (ram_saverdy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_req(input int id, input logic wr, input logic [14:0] a,
                          input logic [31:0] d);
      we[id]          = wr;
      addr[id*15+:15] = a;
      din[id*32+:32]  = d;
   endtask

   // Wait for the strobe, answer k cycles after ISSUE, check the completion.
   task automatic serve(input int id, input logic wr, input int k, input logic [31:0] rdata,
                        input bit drop);
      int n;
      n = 0;
      while (!(ram_start || ram_we) && n < 20) begin
         tick();
         n++;
      end
      chk("strobe_seen", 64'(n < 20), 64'd1);
      chk("gnt_id", 64'(gnt_id), 64'(id));
      chk("strobe_kind", 64'({ram_we, ram_start}), wr ? 64'd2 : 64'd1);
      chk("ram_addr", 64'(ram_addr), 64'(addr[id*15+:15]));
      if (wr) chk("ram_din", 64'(ram_din), 64'(din[id*32+:32]));
      for (int i = 0; i < k; i++) begin
         tick();
         chk("strobe_once", 64'({ram_we, ram_start}), 64'd0);
         chk("done_early", 64'(done), 64'd0);
      end
      if (wr) ram_saverdy = 1'b1;
      else begin
         ram_readrdy = 1'b1;
         ram_dout    = rdata;
      end
      tick();
      ram_saverdy = 1'b0;
      ram_readrdy = 1'b0;
      chk("done", 64'(done), 64'(4'b0001 << id));
      chk("err", 64'(err), 64'd0);
      chk("dout", 64'(dout), wr ? 64'd0 : 64'(rdata));
      chk("addr_hold", 64'(ram_addr), 64'(addr[id*15+:15]));
      if (drop) req[id] = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      req         = '0;
      we          = '0;
      addr        = '0;
      din         = '0;
      ram_dout    = 32'h0;
      ram_readrdy = 1'b0;
      ram_saverdy = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state.
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_outs", 64'({done, err, gnt_id, ram_we, ram_start}), 64'd0);
      chk("rst_data", {dout, ram_din}, 64'd0);
      chk("rst_addr", 64'(ram_addr), 64'd0);

      // Single read: strobe in cycle 1, ready in cycle 2, done in cycle 3.
      set_req(0, 1'b0, 15'h0010, 32'h0);
      req[0] = 1'b1;
      tick();
      chk("read_start_c1", 64'(ram_start), 64'd1);
      chk("read_busy_c1", 64'(busy), 64'd1);
      serve(0, 1'b0, 1, 32'hDEADBEEF, 1'b1);
      tick();
      chk("read_done_clear", 64'(done), 64'd0);
      chk("read_idle", 64'(busy), 64'd0);

      // Contention from reset: order 0,1,2,3.
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 15'(16'h0100 + i), 32'h0);
      req = 4'b1111;
      serve(0, 1'b0, 1, 32'h0000_1000, 1'b1);
      serve(1, 1'b0, 1, 32'h0000_1001, 1'b1);
      serve(2, 1'b0, 2, 32'h0000_1002, 1'b1);
      serve(3, 1'b0, 1, 32'h0000_1003, 1'b1);

      // Leave last_grant=1, then re-request all: order 2,3,0,1.
      req = 4'b0011;
      serve(0, 1'b0, 1, 32'hAAAA_0000, 1'b1);
      serve(1, 1'b0, 1, 32'hAAAA_0001, 1'b1);
      req = 4'b1111;
      serve(2, 1'b0, 1, 32'hBBBB_0002, 1'b1);
      serve(3, 1'b0, 1, 32'hBBBB_0003, 1'b1);
      serve(0, 1'b0, 1, 32'hBBBB_0000, 1'b1);
      serve(1, 1'b0, 1, 32'hBBBB_0001, 1'b1);

      // Sticky requester 2 holds req one cycle past done.
      req = 4'b0100;
      serve(2, 1'b0, 1, 32'hCAFE_0002, 1'b0);
      tick();
      chk("sticky_idle", 64'(busy), 64'd0);
      req[2] = 1'b0;
      tick();
      chk("sticky_no_regrant", 64'({busy, ram_start}), 64'd0);

      // Write with saverdy 5 cycles after ISSUE.
      set_req(1, 1'b1, 15'h7FFF, 32'h12345678);
      req = 4'b0010;
      serve(1, 1'b1, 5, 32'h0, 1'b1);

      // Timeout on the TIMEOUT=4 instance, with a spurious saverdy in WAIT.
      do_reset();
      ram_dout = 32'hA5A5A5A5;
      set_req(0, 1'b0, 15'h0123, 32'h0);
      req = 4'b0001;
      tick();
      chk("to_start", 64'(t_ram_start), 64'd1);
      tick();
      tick();
      ram_saverdy = 1'b1;
      tick();
      ram_saverdy = 1'b0;
      tick();
      tick();
      chk("to_not_yet", 64'(t_done), 64'd0);
      tick();
      chk("to_done", 64'(t_done), 64'd1);
      chk("to_err", 64'(t_err), 64'd1);
      chk("to_dout", 64'(t_dout), 64'd0);
      req = 4'b0000;
      tick();
      chk("to_busy_low", 64'(t_busy), 64'd0);
      chk("to_pulse_end", 64'({t_done, t_err}), 64'd0);
      chk("wrong_rdy_ignored", 64'({busy, done}), 64'h10);

      // Reset while the long-timeout instance sits in WAIT.
      do_reset();
      chk("wrst_outs", 64'({done, err, busy, gnt_id, ram_we, ram_start}), 64'd0);
      chk("wrst_data", {dout, ram_din}, 64'd0);
      chk("wrst_addr", 64'(ram_addr), 64'd0);
      tick();
      chk("wrst_no_done", 64'(done), 64'd0);
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 15'(16'h0200 + i), 32'h0);
      req = 4'b1111;
      serve(0, 1'b0, 1, 32'h5555_AAAA, 1'b1);
      req = 4'b0000;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
